// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary bundle: instruction-memory read port, IDU handoff, and
// writeback PC update. master = fetch unit, slave = surrounding core/memory.
interface ifu_fetch_if;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        pc_wen;
  logic [31:0] pc_wdata;
  logic [31:0] pc;
  logic        fetch_err;
  logic [1:0]  err_cause;

  modport master (
    output imem_arvalid, imem_araddr, imem_rready,
    output inst_valid, inst, inst_pc, pc, fetch_err, err_cause,
    input  imem_arready, imem_rvalid, imem_rdata, imem_rresp,
    input  inst_ready, pc_wen, pc_wdata
  );

  modport slave (
    input  imem_arvalid, imem_araddr, imem_rready,
    input  inst_valid, inst, inst_pc, pc, fetch_err, err_cause,
    output imem_arready, imem_rvalid, imem_rdata, imem_rresp,
    output inst_ready, pc_wen, pc_wdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Handshaked multi-cycle instruction fetch stage: one imem read per
// instruction, hands the word to IDU, then waits for writeback's next PC.
//
// state | meaning
// IDLE  | held in reset, leaves on first edge after release
// REQ   | read request on imem (or misalignment trap)
// RESP  | waiting for read data
// OUT   | instruction offered to IDU
// EXEC  | waiting for writeback to commit next PC
// ERR   | terminal fault, only reset exits
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  ifu_fetch_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] RESP = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
  localparam logic [2:0] EXEC = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  logic [2:0]  state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [1:0]  cause_q;
  logic        pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      cause_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (!pc_aligned) begin
            state   <= ERR;
            cause_q <= 2'b01;
          end else if (bus.imem_arready) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.imem_rvalid) begin
            if (bus.imem_rresp != 2'b00) begin
              state   <= ERR;
              cause_q <= 2'b10;
            end else begin
              inst_q    <= bus.imem_rdata;
              inst_pc_q <= pc_q;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (bus.inst_ready) state <= EXEC;
        end
        EXEC: begin
          if (bus.pc_wen) begin
            pc_q  <= bus.pc_wdata;
            state <= REQ;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // A misaligned PC spends one cycle in REQ on its way to ERR without requesting.
  assign bus.imem_arvalid = (state == REQ) && pc_aligned;
  assign bus.imem_araddr  = pc_q;
  assign bus.imem_rready  = (state == RESP);
  assign bus.inst_valid   = (state == OUT);
  assign bus.inst         = inst_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.pc           = pc_q;
  assign bus.fetch_err    = (state == ERR);
  assign bus.err_cause    = cause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: zero-wait fetch, sequential loop, stalls,
// misaligned PC, bus error, and asynchronous reset in RESP.
module tb_ifu_fetch;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   req_cnt = 0;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk)
    if (sys_rst && bus.imem_arvalid && bus.imem_arready) req_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    bus.imem_arready = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.imem_rresp   = 2'b00;
    bus.inst_ready   = 1'b0;
    bus.pc_wen       = 1'b0;
    bus.pc_wdata     = 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_arvalid"}, {31'h0, bus.imem_arvalid}, 32'h0);
    check({tag, "_rready"},  {31'h0, bus.imem_rready},  32'h0);
    check({tag, "_ivalid"},  {31'h0, bus.inst_valid},   32'h0);
    check({tag, "_pc"},      bus.pc,                    32'h8000_0000);
    check({tag, "_inst"},    bus.inst,                  32'h0);
    check({tag, "_inst_pc"}, bus.inst_pc,               32'h0);
    check({tag, "_err"},     {31'h0, bus.fetch_err},    32'h0);
    check({tag, "_cause"},   {30'h0, bus.err_cause},    32'h0);
  endtask

  // Assumes DUT is in REQ at entry; leaves it in EXEC, then commits next_pc.
  task automatic zero_wait_fetch(input logic [31:0] addr, input logic [31:0] word,
                                 input logic [31:0] next_pc);
    bus.imem_arready = 1'b1;
    bus.imem_rvalid  = 1'b1;
    bus.imem_rdata   = word;
    bus.imem_rresp   = 2'b00;
    bus.inst_ready   = 1'b1;
    check("zw_arvalid", {31'h0, bus.imem_arvalid}, 32'h1);
    check("zw_araddr", bus.imem_araddr, addr);
    tick();
    check("zw_rready", {31'h0, bus.imem_rready}, 32'h1);
    check("zw_ivalid_n1", {31'h0, bus.inst_valid}, 32'h0);
    tick();
    check("zw_ivalid_n2", {31'h0, bus.inst_valid}, 32'h1);
    check("zw_inst", bus.inst, word);
    check("zw_inst_pc", bus.inst_pc, addr);
    tick();
    check("zw_exec_ivalid", {31'h0, bus.inst_valid}, 32'h0);
    check("zw_exec_arvalid", {31'h0, bus.imem_arvalid}, 32'h0);
    bus.pc_wen   = 1'b1;
    bus.pc_wdata = next_pc;
    tick();
    bus.pc_wen = 1'b0;
    check("zw_next_pc", bus.pc, next_pc);
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    idle_inputs();
    sys_rst = 1'b0;
    tick();
    check_reset_state("rst");
    sys_rst = 1'b1;
    tick();

    // Zero-wait first fetch, then sequential loop of 4 instructions.
    zero_wait_fetch(32'h8000_0000, 32'h0010_0093, 32'h8000_0004);
    do_reset();
    base = req_cnt;
    for (int i = 0; i < 4; i++)
      zero_wait_fetch(32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 20),
                      32'h8000_0004 + 32'(4 * i));
    check("loop_reqs", 32'(req_cnt - base), 32'd4);

    // Stalls: arready 3 cycles late, rvalid 2 late, inst_ready 5 late.
    base = req_cnt;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("stall_arvalid", {31'h0, bus.imem_arvalid}, 32'h1);
      check("stall_araddr", bus.imem_araddr, 32'h8000_0010);
      tick();
    end
    bus.imem_arready = 1'b1;
    tick();
    bus.imem_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_rready", {31'h0, bus.imem_rready}, 32'h1);
      check("stall_arvalid_resp", {31'h0, bus.imem_arvalid}, 32'h0);
      tick();
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00A0_0513;
    tick();
    bus.imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("stall_ivalid", {31'h0, bus.inst_valid}, 32'h1);
      check("stall_inst", bus.inst, 32'h00A0_0513);
      check("stall_inst_pc", bus.inst_pc, 32'h8000_0010);
      tick();
    end
    bus.imem_rvalid = 1'b0;
    bus.inst_ready  = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("stall_exec", {31'h0, bus.inst_valid}, 32'h0);
    check("stall_reqs", 32'(req_cnt - base), 32'd1);

    // Misaligned next PC.
    base = req_cnt;
    bus.pc_wen   = 1'b1;
    bus.pc_wdata = 32'h8000_0102;
    tick();
    bus.pc_wen = 1'b0;
    check("mis_arvalid", {31'h0, bus.imem_arvalid}, 32'h0);
    tick();
    check("mis_err", {31'h0, bus.fetch_err}, 32'h1);
    check("mis_cause", {30'h0, bus.err_cause}, 32'h1);
    bus.pc_wen   = 1'b1;
    bus.pc_wdata = 32'h8000_0200;
    tick();
    bus.pc_wen = 1'b0;
    tick();
    check("mis_pc_frozen", bus.pc, 32'h8000_0102);
    check("mis_outs", {29'h0, bus.imem_arvalid, bus.imem_rready, bus.inst_valid}, 32'h0);
    check("mis_reqs", 32'(req_cnt - base), 32'd0);

    // Bus error on first fetch.
    do_reset();
    bus.imem_arready = 1'b1;
    bus.imem_rvalid  = 1'b1;
    bus.imem_rresp   = 2'b10;
    bus.inst_ready   = 1'b1;
    tick();
    tick();
    check("berr_ivalid", {31'h0, bus.inst_valid}, 32'h0);
    check("berr_err", {31'h0, bus.fetch_err}, 32'h1);
    check("berr_cause", {30'h0, bus.err_cause}, 32'h2);
    tick();
    check("berr_sticky", {31'h0, bus.fetch_err}, 32'h1);
    idle_inputs();
    sys_rst = 1'b0;
    tick();
    check("berr_rst_err", {31'h0, bus.fetch_err}, 32'h0);
    check("berr_rst_cause", {30'h0, bus.err_cause}, 32'h0);
    sys_rst = 1'b1;
    tick();
    check("berr_restart", bus.imem_araddr, 32'h8000_0000);
    check("berr_restart_v", {31'h0, bus.imem_arvalid}, 32'h1);

    // Reset asserted while waiting in RESP.
    zero_wait_fetch(32'h8000_0000, 32'h1234_5678, 32'h8000_0004);
    idle_inputs();
    bus.imem_arready = 1'b1;
    tick();
    bus.imem_arready = 1'b0;
    check("mid_in_resp", {31'h0, bus.imem_rready}, 32'h1);
    #2 sys_rst = 1'b0;
    #1 check_reset_state("mid");
    @(negedge sys_clk);
    tick();
    sys_rst = 1'b1;
    tick();
    check("mid_restart", bus.imem_araddr, 32'h8000_0000);
    check("mid_restart_v", {31'h0, bus.imem_arvalid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
